// File: rtl/dpram_rd_ctrl_if.sv
// Valid/ready word stream leaving the DPRAM read-burst engine.
// The master drives data/valid/last; the slave returns ready.
interface dpram_rd_ctrl_if #(
  parameter int WD = 8
) ();
  logic [WD-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/dpram_rd_ctrl.sv
// Read-burst engine for the dual-port RAM read port; returned words leave as a valid/ready stream.
// Optional abort/flush support is built in when DPRAM_RD_CTRL_ABORT_EN is defined.
module dpram_rd_ctrl #(
  parameter int WD = 8,
  parameter int AD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AD-1:0] base_addr,
  input  logic [AD:0]   len,
`ifdef DPRAM_RD_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic          ram_cs_n,
  output logic          ram_rd_n,
  output logic [AD-1:0] ram_addr,
  input  logic [WD-1:0] ram_dout,
  dpram_rd_ctrl_if.master m
);

`ifdef DPRAM_RD_CTRL_ABORT_EN
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FLUSH} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
`endif

  state_t        state_q, state_nx;
  logic [AD-1:0] addr_q;
  logic [AD:0]   remaining_q;
  logic [AD:0]   beats_q;
  logic          pend_q;
  logic [1:0]    cnt_q;
  logic [WD-1:0] fifo_q [3];
  logic          done_q, done_nx;
  logic          load, issue, pop, push, flush;
  logic [1:0]    wr_idx;

  // Issue decision uses registered state only, so the RAM strobe never follows an input.
  assign issue  = (state_q == READ) && (remaining_q != '0) &&
                  (({1'b0, cnt_q} + {2'b00, pend_q}) < 3'd3);
  assign pop    = m.m_valid && m.m_ready;
  assign push   = pend_q;
  assign wr_idx = pop ? (cnt_q - 2'd1) : cnt_q;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign ram_cs_n  = ~busy;
  assign ram_rd_n  = ~issue;
  assign ram_addr  = addr_q;
  assign m.m_valid = (cnt_q != 2'd0);
  assign m.m_data  = fifo_q[0];
  assign m.m_last  = m.m_valid && (beats_q == {{AD{1'b0}}, 1'b1});

  always_comb begin
    state_nx = state_q;
    done_nx  = 1'b0;
    load     = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_nx = 1'b1;
          end else begin
            load     = 1'b1;
            state_nx = READ;
          end
        end
      end
      READ: begin
        if (issue && (remaining_q == {{AD{1'b0}}, 1'b1})) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!pend_q && pop && m.m_last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
`ifdef DPRAM_RD_CTRL_ABORT_EN
      FLUSH: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
`endif
      default: state_nx = IDLE;
    endcase
`ifdef DPRAM_RD_CTRL_ABORT_EN
    // Abort wins over a coinciding final handshake so done timing is fixed at two cycles.
    if (abort && ((state_q == READ) || (state_q == DRAIN))) begin
      state_nx = FLUSH;
      done_nx  = 1'b0;
      flush    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= 2'd0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      fifo_q[2]   <= '0;
    end else begin
      state_q <= state_nx;
      done_q  <= done_nx;
      pend_q  <= issue;
      if (load) begin
        addr_q      <= base_addr;
        remaining_q <= len;
        beats_q     <= len;
      end
      if (issue) begin
        addr_q      <= addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      if (pop) begin
        beats_q   <= beats_q - 1'b1;
        fifo_q[0] <= fifo_q[1];
        fifo_q[1] <= fifo_q[2];
      end
      if (push) fifo_q[wr_idx] <= ram_dout;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (flush) begin
        cnt_q  <= 2'd0;
        pend_q <= 1'b0;
      end
    end
  end

endmodule
